multicycle_ctrl: RTL and testbench

//  Moore/Mealy control FSM sequencing a multicycle LEGv8 datapath (shared ALU, one unified memory) for LDUR, STUR, CBZ, ADD/SUB/AND/ORR.

---
 rtl/legv8_ctrl_pkg.sv | 48 ++++
 rtl/op_classify.sv | 23 ++
 rtl/multicycle_ctrl.sv | 202 ++++++++++++++++++++
 tb/tb_multicycle_ctrl.sv | 300 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/legv8_ctrl_pkg.sv
// Shared types and encodings for the multicycle LEGv8 control unit:
// FSM states, instruction classes, opcode patterns and control-field codes.
package legv8_ctrl_pkg;

  typedef enum logic [3:0] {
    FETCH  = 4'd0,
    DECODE = 4'd1,
    MEMADR = 4'd2,
    MEMRD  = 4'd3,
    LDWB   = 4'd4,
    MEMWR  = 4'd5,
    EXEC_R = 4'd6,
    RWB    = 4'd7,
    BRANCH = 4'd8,
    EXC    = 4'd9
  } state_t;

  typedef enum logic [2:0] {
    IC_LD  = 3'd0,
    IC_ST  = 3'd1,
    IC_CBZ = 3'd2,
    IC_R   = 3'd3,
    IC_BAD = 3'd4
  } iclass_t;

  localparam logic [10:0] OP_LDUR = 11'b11111000010;
  localparam logic [10:0] OP_STUR = 11'b11111000000;
  localparam logic [10:0] OP_ADD  = 11'b10001011000;
  localparam logic [10:0] OP_SUB  = 11'b11001011000;
  localparam logic [10:0] OP_AND  = 11'b10001010000;
  localparam logic [10:0] OP_ORR  = 11'b10101010000;
  // CBZ carries part of its immediate in Op[2:0]; only the top 8 bits identify it.
  localparam logic [7:0]  OP_CBZ_PFX = 8'b10110100;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_PASSB = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;

  localparam logic [1:0] SRCB_REGB = 2'b00;
  localparam logic [1:0] SRCB_FOUR = 2'b01;
  localparam logic [1:0] SRCB_DOFF = 2'b10;
  localparam logic [1:0] SRCB_BOFF = 2'b11;

  localparam logic [1:0] EXC_NONE    = 2'b00;
  localparam logic [1:0] EXC_BADOP   = 2'b01;
  localparam logic [1:0] EXC_TIMEOUT = 2'b10;

endpackage

// File: rtl/op_classify.sv
// Combinational opcode decoder: maps IR[31:21] onto an instruction class.
module op_classify
  import legv8_ctrl_pkg::*;
(
  input  logic [10:0] i_op,
  output iclass_t     o_iclass
);

  always_comb begin
    o_iclass = IC_BAD;
    if (i_op == OP_LDUR) begin
      o_iclass = IC_LD;
    end else if (i_op == OP_STUR) begin
      o_iclass = IC_ST;
    end else if (i_op[10:3] == OP_CBZ_PFX) begin
      o_iclass = IC_CBZ;
    end else if ((i_op == OP_ADD) || (i_op == OP_SUB) ||
                 (i_op == OP_AND) || (i_op == OP_ORR)) begin
      o_iclass = IC_R;
    end
  end

endmodule

// File: rtl/multicycle_ctrl.sv
// Control FSM for a multicycle LEGv8 datapath with a shared ALU and unified,
// variable-latency memory; counts retired instructions and traps faults.
module multicycle_ctrl
  import legv8_ctrl_pkg::*;
#(
  parameter int MEM_TIMEOUT = 15,
  parameter int CNT_W       = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [10:0]      Op,
  input  logic             Zero,
  input  logic             mem_ready,
  output logic             PCWrite,
  output logic             IRWrite,
  output logic             IorD,
  output logic             MemRead,
  output logic             MemWrite,
  output logic             Reg2Loc,
  output logic             ALUSrcA,
  output logic             MemtoReg,
  output logic             RegWrite,
  output logic             PCSrc,
  output logic [1:0]       ALUSrcB,
  output logic [1:0]       ALUOp,
  output logic             exc,
  output logic [1:0]       exc_cause,
  output logic [CNT_W-1:0] retired,
  output logic [3:0]       state_o
);

  localparam int WAIT_W = (MEM_TIMEOUT > 0) ? $clog2(MEM_TIMEOUT + 1) : 1;
  localparam logic [WAIT_W-1:0] WAIT_SAT    = '1;
  localparam logic [WAIT_W:0]   TIMEOUT_CNT = (WAIT_W + 1)'(MEM_TIMEOUT);

  state_t             r_state;
  iclass_t            r_iclass;
  logic [WAIT_W-1:0]  r_wait;
  logic               r_exc;
  logic [1:0]         r_cause;
  logic [CNT_W-1:0]   r_retired;

  iclass_t            w_iclass;
  logic               w_mem_state;
  logic [WAIT_W:0]    w_wait_inc;
  logic               w_timeout;

  op_classify u_op_classify (
    .i_op     (Op),
    .o_iclass (w_iclass)
  );

  assign w_mem_state = (r_state == FETCH) || (r_state == MEMRD) || (r_state == MEMWR);
  assign w_wait_inc  = {1'b0, r_wait} + 1'b1;
  // A late mem_ready in the final allowed cycle still completes the access.
  assign w_timeout   = (MEM_TIMEOUT != 0) && w_mem_state && !mem_ready &&
                       (w_wait_inc == TIMEOUT_CNT);

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state   <= FETCH;
      r_iclass  <= IC_BAD;
      r_wait    <= '0;
      r_exc     <= 1'b0;
      r_cause   <= EXC_NONE;
      r_retired <= '0;
    end else begin
      // Non-memory states hold the counter at zero, so every memory state starts fresh.
      if (!w_mem_state || mem_ready) begin
        r_wait <= '0;
      end else if (r_wait != WAIT_SAT) begin
        r_wait <= r_wait + 1'b1;
      end

      case (r_state)
        FETCH: begin
          if (mem_ready) begin
            r_state <= DECODE;
          end else if (w_timeout) begin
            r_state <= EXC;
            r_exc   <= 1'b1;
            r_cause <= EXC_TIMEOUT;
          end
        end
        DECODE: begin
          r_iclass <= w_iclass;
          case (w_iclass)
            IC_LD, IC_ST: r_state <= MEMADR;
            IC_CBZ:       r_state <= BRANCH;
            IC_R:         r_state <= EXEC_R;
            default: begin
              r_state <= EXC;
              r_exc   <= 1'b1;
              r_cause <= EXC_BADOP;
            end
          endcase
        end
        MEMADR: r_state <= (r_iclass == IC_ST) ? MEMWR : MEMRD;
        MEMRD: begin
          if (mem_ready) begin
            r_state <= LDWB;
          end else if (w_timeout) begin
            r_state <= EXC;
            r_exc   <= 1'b1;
            r_cause <= EXC_TIMEOUT;
          end
        end
        LDWB: begin
          r_state   <= FETCH;
          r_retired <= r_retired + 1'b1;
        end
        MEMWR: begin
          if (mem_ready) begin
            r_state   <= FETCH;
            r_retired <= r_retired + 1'b1;
          end else if (w_timeout) begin
            r_state <= EXC;
            r_exc   <= 1'b1;
            r_cause <= EXC_TIMEOUT;
          end
        end
        EXEC_R: r_state <= RWB;
        RWB, BRANCH: begin
          r_state   <= FETCH;
          r_retired <= r_retired + 1'b1;
        end
        EXC:     r_state <= EXC;
        default: r_state <= FETCH;
      endcase
    end
  end

  always_comb begin
    PCWrite  = 1'b0;
    IRWrite  = 1'b0;
    IorD     = 1'b0;
    MemRead  = 1'b0;
    MemWrite = 1'b0;
    Reg2Loc  = 1'b0;
    ALUSrcA  = 1'b0;
    MemtoReg = 1'b0;
    RegWrite = 1'b0;
    PCSrc    = 1'b0;
    ALUSrcB  = SRCB_REGB;
    ALUOp    = ALUOP_ADD;
    if (!reset) begin
      case (r_state)
        FETCH: begin
          MemRead = 1'b1;
          if (mem_ready) begin
            IRWrite = 1'b1;
            PCWrite = 1'b1;
            ALUSrcB = SRCB_FOUR;
          end
        end
        DECODE: begin
          ALUSrcB = SRCB_BOFF;
          Reg2Loc = (w_iclass == IC_ST) || (w_iclass == IC_CBZ);
        end
        MEMADR: begin
          ALUSrcA = 1'b1;
          ALUSrcB = SRCB_DOFF;
          Reg2Loc = (r_iclass == IC_ST);
        end
        MEMRD: begin
          IorD    = 1'b1;
          MemRead = 1'b1;
        end
        LDWB: begin
          RegWrite = 1'b1;
          MemtoReg = 1'b1;
        end
        MEMWR: begin
          IorD     = 1'b1;
          MemWrite = 1'b1;
          Reg2Loc  = 1'b1;
        end
        EXEC_R: begin
          ALUSrcA = 1'b1;
          ALUSrcB = SRCB_REGB;
          ALUOp   = ALUOP_FUNCT;
        end
        RWB: RegWrite = 1'b1;
        BRANCH: begin
          Reg2Loc = 1'b1;
          ALUSrcA = 1'b1;
          ALUSrcB = SRCB_REGB;
          ALUOp   = ALUOP_PASSB;
          PCSrc   = 1'b1;
          PCWrite = Zero;
        end
        default: ;
      endcase
    end
  end

  assign exc       = r_exc;
  assign exc_cause = r_cause;
  assign retired   = r_retired;
  assign state_o   = r_state;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Self-checking bench for multicycle_ctrl: vector table, hand-built corner
// sequences and randomized instruction streams against an instruction-level model.
module tb_multicycle_ctrl;
  import legv8_ctrl_pkg::*;

  localparam int TB_TIMEOUT = 15;
  localparam int TB_CNT_W   = 4;

  logic                clk = 1'b0;
  logic                reset = 1'b1;
  logic [10:0]         Op = '0;
  logic                Zero = 1'b0;
  logic                mem_ready = 1'b0;
  logic                PCWrite, IRWrite, IorD, MemRead, MemWrite, Reg2Loc;
  logic                ALUSrcA, MemtoReg, RegWrite, PCSrc;
  logic [1:0]          ALUSrcB, ALUOp;
  logic                exc;
  logic [1:0]          exc_cause;
  logic [TB_CNT_W-1:0] retired;
  logic [3:0]          state_o;

  int n_tests = 0;
  int n_fail  = 0;
  int exp_ret = 0;

  typedef struct {
    logic [10:0] op;
    bit          zero;
    int          wf, wm;
    int          cyc, rw, mw, pcw, r2l, mrd;
    bit          trap;
    int          cause;
  } vec_t;

  typedef struct {
    int cyc, rw, mw, pcw, r2l, mrd, mtr, irw;
    bit trap;
  } res_t;

  multicycle_ctrl #(.MEM_TIMEOUT(TB_TIMEOUT), .CNT_W(TB_CNT_W)) dut (
    .clk(clk), .reset(reset), .Op(Op), .Zero(Zero), .mem_ready(mem_ready),
    .PCWrite(PCWrite), .IRWrite(IRWrite), .IorD(IorD), .MemRead(MemRead),
    .MemWrite(MemWrite), .Reg2Loc(Reg2Loc), .ALUSrcA(ALUSrcA), .MemtoReg(MemtoReg),
    .RegWrite(RegWrite), .PCSrc(PCSrc), .ALUSrcB(ALUSrcB), .ALUOp(ALUOp),
    .exc(exc), .exc_cause(exc_cause), .retired(retired), .state_o(state_o)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  function automatic int ctrl_bits();
    return int'({PCWrite, IRWrite, IorD, MemRead, MemWrite, Reg2Loc, ALUSrcA,
                 MemtoReg, RegWrite, PCSrc, ALUSrcB, ALUOp});
  endfunction

  task automatic check(input string name, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Ends between posedge and negedge with the DUT in its first post-reset cycle.
  task automatic do_reset(input string tag);
    @(negedge clk);
    reset = 1'b1;
    mem_ready = 1'b1;
    Op = OP_LDUR;
    #1;
    check({tag, " ctrl during reset"}, ctrl_bits(), 0);
    @(posedge clk);
    #1;
    reset = 1'b0;
    check({tag, " state after reset"}, int'(state_o), int'(FETCH));
    check({tag, " retired after reset"}, int'(retired), 0);
    check({tag, " exc after reset"}, int'(exc), 0);
    check({tag, " cause after reset"}, int'(exc_cause), 0);
    exp_ret = 0;
  endtask

  // Acts as the memory: holds mem_ready low for wf fetch waits and wm data waits.
  task automatic run_instr(input logic [10:0] op, input bit zero, input int wf,
                           input int wm, input bit scramble, output res_t r);
    int rf, rm, guard;
    bit seen_dec, done;
    r = '{default: 0};
    rf = wf; rm = wm; guard = 0; seen_dec = 0; done = 0;
    while (!done) begin
      @(negedge clk);
      Zero = zero;
      if (MemRead && !IorD) begin
        Op = scramble ? 11'($urandom) : op;
        mem_ready = (rf == 0);
        if (rf > 0) rf--;
      end else if (!seen_dec) begin
        Op = op;
        seen_dec = 1;
        mem_ready = 1'($urandom);
      end else begin
        Op = scramble ? 11'($urandom) : op;
        if (MemRead || MemWrite) begin
          mem_ready = (rm == 0);
          if (rm > 0) rm--;
        end else begin
          mem_ready = 1'($urandom);
        end
      end
      #1;
      r.cyc++;
      if (RegWrite) r.rw++;
      if (MemWrite) r.mw++;
      if (PCWrite) r.pcw++;
      if (Reg2Loc) r.r2l++;
      if (MemRead && IorD) r.mrd++;
      if (MemtoReg) r.mtr++;
      if (IRWrite) r.irw++;
      @(posedge clk);
      #1;
      guard++;
      if (exc) begin
        r.trap = 1;
        done = 1;
      end else if (seen_dec && MemRead && !IorD) begin
        done = 1;
      end else if (guard >= 60) begin
        n_tests++;
        n_fail++;
        $display("FAIL run_instr bound: op=%b still running after %0d cycles", op, guard);
        done = 1;
      end
    end
  endtask

  // Instruction-level expectations from the class latencies and memory waits.
  function automatic vec_t model(input logic [10:0] op, input bit zero,
                                 input int wf, input int wm);
    vec_t v;
    v = '{op, zero, wf, wm, 0, 0, 0, 1, 0, 0, 0, 0};
    if (op == 11'b11111000010) begin
      v.cyc = 5 + wf + wm; v.rw = 1; v.mrd = 1 + wm;
    end else if (op == 11'b11111000000) begin
      v.cyc = 4 + wf + wm; v.mw = 1 + wm; v.r2l = 3 + wm;
    end else if (op[10:3] == 8'b10110100) begin
      v.cyc = 3 + wf; v.pcw = 1 + int'(zero); v.r2l = 2;
    end else if (op == 11'b10001011000 || op == 11'b11001011000 ||
                 op == 11'b10001010000 || op == 11'b10101010000) begin
      v.cyc = 4 + wf; v.rw = 1;
    end else begin
      v.cyc = 2 + wf; v.trap = 1; v.cause = 1;
    end
    return v;
  endfunction

  task automatic apply_vec(input string tag, input vec_t v, input bit scramble);
    res_t r;
    run_instr(v.op, v.zero, v.wf, v.wm, scramble, r);
    check({tag, " cycles"}, r.cyc, v.cyc);
    check({tag, " RegWrite cycles"}, r.rw, v.rw);
    check({tag, " MemWrite cycles"}, r.mw, v.mw);
    check({tag, " PCWrite cycles"}, r.pcw, v.pcw);
    check({tag, " Reg2Loc cycles"}, r.r2l, v.r2l);
    check({tag, " data read cycles"}, r.mrd, v.mrd);
    check({tag, " trap"}, int'(r.trap), int'(v.trap));
    if (v.trap) begin
      check({tag, " exc_cause"}, int'(exc_cause), v.cause);
      for (int k = 0; k < 3; k++) begin
        @(negedge clk);
        mem_ready = 1'b1;
        Zero = 1'b1;
        Op = 11'($urandom);
        #1;
        check({tag, " ctrl held in trap"}, ctrl_bits(), 0);
        check({tag, " exc sticky"}, int'(exc), 1);
      end
      do_reset({tag, " recover"});
    end else begin
      exp_ret = (exp_ret + 1) % (1 << TB_CNT_W);
      check({tag, " retired"}, int'(retired), exp_ret);
    end
  endtask

  vec_t   tbl[18];
  state_t exp_st[4];
  int     exp_srcb[4];
  int     exp_aluop[4];

  initial begin
    tbl[0]  = '{11'b10001011000, 0, 0, 0,    4, 1, 0, 1, 0, 0, 0, 0};
    tbl[1]  = '{11'b11001011000, 0, 2, 0,    6, 1, 0, 1, 0, 0, 0, 0};
    tbl[2]  = '{11'b10001010000, 0, 0, 0,    4, 1, 0, 1, 0, 0, 0, 0};
    tbl[3]  = '{11'b10101010000, 1, 1, 0,    5, 1, 0, 1, 0, 0, 0, 0};
    tbl[4]  = '{11'b11111000010, 0, 0, 0,    5, 1, 0, 1, 0, 1, 0, 0};
    tbl[5]  = '{11'b11111000010, 0, 0, 3,    8, 1, 0, 1, 0, 4, 0, 0};
    tbl[6]  = '{11'b11111000000, 0, 0, 0,    4, 0, 1, 1, 3, 0, 0, 0};
    tbl[7]  = '{11'b11111000000, 0, 1, 2,    7, 0, 3, 1, 5, 0, 0, 0};
    tbl[8]  = '{11'b10110100101, 1, 0, 0,    3, 0, 0, 2, 2, 0, 0, 0};
    tbl[9]  = '{11'b10110100101, 0, 0, 0,    3, 0, 0, 1, 2, 0, 0, 0};
    tbl[10] = '{11'b10110100000, 1, 1, 0,    4, 0, 0, 2, 2, 0, 0, 0};
    tbl[11] = '{11'b11111000000, 0, 0, 14,  18, 0, 15, 1, 17, 0, 0, 0};
    tbl[12] = '{11'b11111000000, 0, 0, 100, 18, 0, 15, 1, 17, 0, 1, 2};
    tbl[13] = '{11'b00000000000, 0, 0, 0,    2, 0, 0, 1, 0, 0, 1, 1};
    tbl[14] = '{11'b11111000011, 0, 0, 0,    2, 0, 0, 1, 0, 0, 1, 1};
    tbl[15] = '{11'b10001011000, 0, 100, 0, 15, 0, 0, 0, 0, 0, 1, 2};
    tbl[16] = '{11'b11111000010, 0, 0, 100, 18, 0, 0, 1, 0, 15, 1, 2};
    tbl[17] = '{11'b10110101000, 0, 0, 0,    2, 0, 0, 1, 0, 0, 1, 1};
    exp_st    = '{FETCH, DECODE, EXEC_R, RWB};
    exp_srcb  = '{1, 3, 0, 0};
    exp_aluop = '{0, 0, 2, 0};

    do_reset("init");

    // R-type with zero-wait memory, checked cycle by cycle.
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      Op = OP_ADD;
      mem_ready = 1'b1;
      #1;
      check($sformatf("add step%0d state", k), int'(state_o), int'(exp_st[k]));
      check($sformatf("add step%0d RegWrite", k), int'(RegWrite), int'(k == 3));
      check($sformatf("add step%0d ALUSrcB", k), int'(ALUSrcB), exp_srcb[k]);
      check($sformatf("add step%0d ALUOp", k), int'(ALUOp), exp_aluop[k]);
      @(posedge clk);
      #1;
    end
    exp_ret = 1;
    check("add retired", int'(retired), exp_ret);

    for (int i = 0; i < 18; i++) begin
      apply_vec($sformatf("vec%0d", i), tbl[i], 1'b0);
    end

    // Reset landing on the load write-back cycle aborts the instruction.
    do_reset("ldwb");
    begin
      bit hit;
      hit = 0;
      for (int c = 0; c < 20 && !hit; c++) begin
        @(negedge clk);
        reset = 1'b0;
        Op = OP_LDUR;
        mem_ready = 1'b1;
        #1;
        if (MemtoReg) begin
          hit = 1;
          reset = 1'b1;
          #1;
          check("ldwb reset RegWrite", int'(RegWrite), 0);
          check("ldwb reset MemtoReg", int'(MemtoReg), 0);
          @(posedge clk);
          #1;
          reset = 1'b0;
          check("ldwb reset state", int'(state_o), int'(FETCH));
          check("ldwb reset retired", int'(retired), 0);
          exp_ret = 0;
        end
      end
      check("ldwb reached", int'(hit), 1);
    end

    // Retired counter wraps after 2^CNT_W instructions.
    do_reset("wrap");
    for (int i = 0; i < 16; i++) begin
      res_t r;
      run_instr(OP_ADD, 1'b0, 0, 0, 1'b0, r);
      if (i == 14) check("wrap retired at 15", int'(retired), 15);
      if (i == 15) check("wrap retired at 16", int'(retired), 0);
    end
    exp_ret = 0;

    // Random instruction stream; Op scrambled outside DECODE.
    for (int i = 0; i < 40; i++) begin
      logic [10:0] op;
      int sel;
      sel = $urandom_range(0, 9);
      case (sel)
        0: op = OP_ADD;
        1: op = OP_SUB;
        2: op = OP_AND;
        3: op = OP_ORR;
        4, 5: op = OP_LDUR;
        6, 7: op = OP_STUR;
        8: op = {8'b10110100, 3'($urandom)};
        default: op = 11'($urandom);
      endcase
      apply_vec($sformatf("rnd%0d", i),
                model(op, 1'($urandom), $urandom_range(0, 3), $urandom_range(0, 5)),
                1'b1);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
